alu_operand_pipe: RTL

ALU_OPERAND_PIPE -- requirements
Module: alu_operand_pipe

---
 rtl/alu_pkg.sv | 16 +
 rtl/operand_select.sv | 35 +++
 rtl/alu_operand_pipe.sv | 137 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU operand pipeline: default operand width,
//   default number of selectable sources, and the skid-buffer state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_NSRC  = 4;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/operand_select.sv
// operand_select
//   Combinational NSRC:1 source multiplexer with out-of-range detection.
//   Ports:
//     src_data     in  NSRC*WIDTH  flat source bus, source k at [k*WIDTH +: WIDTH]
//     sel          in  SELW        source index
//     data         out WIDTH       selected source, all-zero when sel >= NSRC
//     out_of_range out 1           sel >= NSRC
module operand_select #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel,
  output logic [WIDTH-1:0]      data,
  output logic                  out_of_range
);

  // One extra bit so NSRC itself is representable (e.g. NSRC=4 with SELW=2).
  localparam logic [SELW:0] NSRC_L = NSRC[SELW:0];

  assign out_of_range = ({1'b0, sel} >= NSRC_L);

  // Indices that match no source fall through to the zero default, which is
  // exactly the required out-of-range result.
  always_comb begin
    data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == k[SELW-1:0]) begin
        data = src_data[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/alu_operand_pipe.sv
// alu_operand_pipe
//   Selects operands A and B from a flat source bus and holds them in a
//   two-entry skid buffer (main + skid) feeding the ALU with valid/ready
//   handshakes on both sides.
//   Ports:
//     clk, reset        clock, synchronous active-high reset
//     in_valid/in_ready upstream request handshake
//     src_data          NSRC*WIDTH flat source bus
//     sel_a, sel_b      source indices for operands A and B
//     out_valid/out_ready ALU-side handshake
//     op_a, op_b        registered operand pair (main entry)
//     sel_err           sticky: an accepted request had an index >= NSRC
module alu_operand_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NSRC  = ALU_NSRC,
  parameter int SELW  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSRC*WIDTH-1:0] src_data,
  input  logic [SELW-1:0]       sel_a,
  input  logic [SELW-1:0]       sel_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      op_a,
  output logic [WIDTH-1:0]      op_b,
  output logic                  sel_err
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_a_q, main_a_d, main_b_q, main_b_d;
  logic [WIDTH-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
  logic             sel_err_q, sel_err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] new_a, new_b;
  logic             err_a, err_b;
  logic             accept, consume;

  operand_select #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) u_sel_a (
    .src_data     (src_data),
    .sel          (sel_a),
    .data         (new_a),
    .out_of_range (err_a)
  );

  operand_select #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW)) u_sel_b (
    .src_data     (src_data),
    .sel          (sel_b),
    .data         (new_b),
    .out_of_range (err_b)
  );

  assign accept  = in_valid & in_ready_q;
  assign consume = out_valid_q & out_ready;

  // The main entry is always the one presented to the ALU; the skid entry
  // only absorbs a request that arrives while main is stalled.
  always_comb begin
    state_d   = state_q;
    main_a_d  = main_a_q;
    main_b_d  = main_b_q;
    skid_a_d  = skid_a_q;
    skid_b_d  = skid_b_q;
    sel_err_d = sel_err_q | (accept & (err_a | err_b));

    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_a_d = new_a;
          main_b_d = new_b;
          state_d  = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          main_a_d = new_a;
          main_b_d = new_b;
        end else if (accept) begin
          skid_a_d = new_a;
          skid_b_d = new_b;
          state_d  = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a consume can happen.
        if (consume) begin
          main_a_d = skid_a_q;
          main_b_d = skid_b_q;
          state_d  = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Handshake outputs are registered copies of the next-state decode, so
    // in_ready has no combinational path from out_ready.
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_a_q    <= '0;
      main_b_q    <= '0;
      skid_a_q    <= '0;
      skid_b_q    <= '0;
      sel_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_a_q    <= main_a_d;
      main_b_q    <= main_b_d;
      skid_a_q    <= skid_a_d;
      skid_b_q    <= skid_b_d;
      sel_err_q   <= sel_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign op_a      = main_a_q;
  assign op_b      = main_b_q;
  assign sel_err   = sel_err_q;

endmodule
